// File: rtl/imm_rotate_encoder_if.sv
// Request/result bundle for the rotated-immediate encoder.
// The master drives start/value; the slave (encoder) returns status and the 12-bit field.
interface imm_rotate_encoder_if;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        found;
    logic [11:0] shifter_operand;
    logic        carry_out;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  found,
        input  shifter_operand,
        input  carry_out
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output found,
        output shifter_operand,
        output carry_out
    );
endinterface

// File: rtl/imm_rotate_encoder.sv
// Sequential search for the canonical ARM rotated-immediate encoding of a 32-bit constant.
// LANES even rotations are tested per clock; the lowest matching rotation wins.
module imm_rotate_encoder #(
    parameter int unsigned LANES = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    imm_rotate_encoder_if.slave bus
);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : gen_bad_lanes
        $error("imm_rotate_encoder: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } state_e;

    localparam logic [4:0] LanesStep = 5'(LANES);

    state_e      state_q;
    logic [31:0] val_q;
    logic [4:0]  rot_base_q;
    logic        busy_q;
    logic        done_q;
    logic        found_q;
    logic [11:0] operand_q;
    logic        carry_q;

    logic        hit;
    logic [3:0]  hit_rot;
    logic [7:0]  hit_imm;
    logic [3:0]  cand;
    logic [63:0] rol64;
    logic        last_chunk;

    // Scan lanes from highest to lowest so the lowest matching rotation is the one kept.
    // The upper half of {val,val} << 2r is ROL(val, 2r).
    always_comb begin
        hit     = 1'b0;
        hit_rot = '0;
        hit_imm = '0;
        cand    = '0;
        rol64   = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            cand  = rot_base_q[3:0] + 4'(i);
            rol64 = {val_q, val_q} << {cand, 1'b0};
            if (rol64[63:40] == 24'd0) begin
                hit     = 1'b1;
                hit_rot = cand;
                hit_imm = rol64[39:32];
            end
        end
    end

    assign last_chunk = (rot_base_q + LanesStep) == 5'd16;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            val_q      <= '0;
            rot_base_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            operand_q  <= '0;
            carry_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        val_q      <= bus.value;
                        rot_base_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StSearch;
                    end
                end
                StSearch: begin
                    if (hit) begin
                        found_q   <= 1'b1;
                        operand_q <= {hit_rot, hit_imm};
                        carry_q   <= (hit_rot != 4'd0) & val_q[31];
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end else if (last_chunk) begin
                        found_q   <= 1'b0;
                        operand_q <= '0;
                        carry_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        rot_base_q <= rot_base_q + LanesStep;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.found           = found_q;
    assign bus.shifter_operand = operand_q;
    assign bus.carry_out       = carry_q;

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Bench for imm_rotate_encoder: three instances (LANES 1, 4, 16) driven in parallel,
// checked against a brute-force decode-path model and a table of known encodings.
module tb_imm_rotate_encoder;

    logic clk;
    logic rst_n;

    logic        start_s [3];
    logic [31:0] value_s;
    logic        busy_s  [3];
    logic        done_s  [3];
    logic        found_s [3];
    logic [11:0] op_s    [3];
    logic        carry_s [3];

    int lanes [3] = '{1, 4, 16};

    int nvec = 0;
    int nmis = 0;

    imm_rotate_encoder_if if_l1 ();
    imm_rotate_encoder_if if_l4 ();
    imm_rotate_encoder_if if_l16 ();

    assign if_l1.start  = start_s[0];
    assign if_l4.start  = start_s[1];
    assign if_l16.start = start_s[2];
    assign if_l1.value  = value_s;
    assign if_l4.value  = value_s;
    assign if_l16.value = value_s;

    assign busy_s[0]  = if_l1.busy;
    assign busy_s[1]  = if_l4.busy;
    assign busy_s[2]  = if_l16.busy;
    assign done_s[0]  = if_l1.done;
    assign done_s[1]  = if_l4.done;
    assign done_s[2]  = if_l16.done;
    assign found_s[0] = if_l1.found;
    assign found_s[1] = if_l4.found;
    assign found_s[2] = if_l16.found;
    assign op_s[0]    = if_l1.shifter_operand;
    assign op_s[1]    = if_l4.shifter_operand;
    assign op_s[2]    = if_l16.shifter_operand;
    assign carry_s[0] = if_l1.carry_out;
    assign carry_s[1] = if_l4.carry_out;
    assign carry_s[2] = if_l16.carry_out;

    imm_rotate_encoder #(.LANES(1)) u_dut_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l1)
    );

    imm_rotate_encoder #(.LANES(4)) u_dut_l4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l4)
    );

    imm_rotate_encoder #(.LANES(16)) u_dut_l16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic        found;
        logic [11:0] op;
        logic        carry;
        int          lat1;
        int          lat4;
        int          lat16;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [31:0] r;
        if (n == 0) r = x;
        else        r = (x >> n) | (x << (32 - n));
        return r;
    endfunction

    // Brute force over every decodable (rot, imm8) pair; first hit is the minimum rotation.
    task automatic model(input logic [31:0] v, output logic f, output logic [11:0] op,
                         output logic c, output int rot);
        f   = 1'b0;
        op  = '0;
        c   = 1'b0;
        rot = 0;
        for (int r = 0; r < 16 && !f; r++) begin
            for (int imm = 0; imm < 256 && !f; imm++) begin
                if (ror32(32'(imm), 2 * r) == v) begin
                    f   = 1'b1;
                    rot = r;
                    op  = {4'(r), 8'(imm)};
                    c   = (r != 0) && v[31];
                end
            end
        end
    endtask

    task automatic encode(input string name, input logic [31:0] v, input logic ef,
                          input logic [11:0] eop, input logic ec,
                          input int l1, input int l4, input int l16, input bit poke);
        int first [3];
        int ndone [3];
        int elat  [3];
        elat[0] = l1;
        elat[1] = l4;
        elat[2] = l16;
        @(negedge clk);
        value_s = v;
        for (int k = 0; k < 3; k++) start_s[k] = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            first[k]   = 0;
            ndone[k]   = 0;
        end
        value_s = ~v;
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s busy L%0d", name, lanes[k]), 32'(busy_s[k]), 32'd1);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (done_s[k]) begin
                    ndone[k]++;
                    if (first[k] == 0) first[k] = cyc;
                end
                // Only poke while the instance is searching or in its done cycle.
                start_s[k] = (poke && (first[k] == 0 || first[k] == cyc)) ? 1'b1 : 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) start_s[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s ndone L%0d", name, lanes[k]), 32'(ndone[k]), 32'd1);
            chk($sformatf("%s latency L%0d", name, lanes[k]), 32'(first[k]), 32'(elat[k]));
            chk($sformatf("%s found L%0d", name, lanes[k]), 32'(found_s[k]), 32'(ef));
            chk($sformatf("%s operand L%0d", name, lanes[k]), 32'(op_s[k]), 32'(eop));
            chk($sformatf("%s carry L%0d", name, lanes[k]), 32'(carry_s[k]), 32'(ec));
        end
    endtask

    vec_t tbl [8];

    initial begin
        logic        mf;
        logic [11:0] mop;
        logic        mc;
        int          mr;
        int          ml [3];
        logic [31:0] v;
        int          nd;

        tbl[0] = '{32'h000000FF, 1'b1, 12'h0FF, 1'b0, 1, 1, 1};
        tbl[1] = '{32'hFF000000, 1'b1, 12'h4FF, 1'b1, 5, 2, 1};
        tbl[2] = '{32'hF000000F, 1'b1, 12'h2FF, 1'b1, 3, 1, 1};
        tbl[3] = '{32'h00000102, 1'b0, 12'h000, 1'b0, 16, 4, 1};
        tbl[4] = '{32'h00000000, 1'b1, 12'h000, 1'b0, 1, 1, 1};
        tbl[5] = '{32'h3FC00000, 1'b1, 12'h5FF, 1'b0, 6, 2, 1};
        tbl[6] = '{32'h00000104, 1'b1, 12'hF41, 1'b0, 16, 4, 1};
        tbl[7] = '{32'h80000001, 1'b1, 12'h106, 1'b1, 2, 1, 1};

        rst_n   = 1'b0;
        value_s = '0;
        for (int k = 0; k < 3; k++) start_s[k] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset busy L%0d", lanes[k]), 32'(busy_s[k]), 32'd0);
            chk($sformatf("reset done L%0d", lanes[k]), 32'(done_s[k]), 32'd0);
            chk($sformatf("reset found L%0d", lanes[k]), 32'(found_s[k]), 32'd0);
            chk($sformatf("reset operand L%0d", lanes[k]), 32'(op_s[k]), 32'd0);
            chk($sformatf("reset carry L%0d", lanes[k]), 32'(carry_s[k]), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            encode($sformatf("tbl%0d", i), tbl[i].value, tbl[i].found, tbl[i].op, tbl[i].carry,
                   tbl[i].lat1, tbl[i].lat4, tbl[i].lat16, (i % 2) == 0);

        // Reset in mid-search: set nonzero results first so the async clear is visible.
        encode("pre_reset", 32'hFF000000, 1'b1, 12'h4FF, 1'b1, 5, 2, 1, 1'b0);
        @(negedge clk);
        value_s = 32'h00000102;
        for (int k = 0; k < 3; k++) start_s[k] = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) start_s[k] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst busy L%0d", lanes[k]), 32'(busy_s[k]), 32'd0);
            chk($sformatf("midrst found L%0d", lanes[k]), 32'(found_s[k]), 32'd0);
            chk($sformatf("midrst operand L%0d", lanes[k]), 32'(op_s[k]), 32'd0);
            chk($sformatf("midrst carry L%0d", lanes[k]), 32'(carry_s[k]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nd = 0;
            for (int c = 0; c < 20; c++) begin
                if (k == 0 || c == 0) begin
                    @(posedge clk);
                    #1;
                end
                if (done_s[k]) nd++;
            end
            chk($sformatf("midrst no_done L%0d", lanes[k]), 32'(nd), 32'd0);
        end
        encode("post_reset", 32'h3FC00000, 1'b1, 12'h5FF, 1'b0, 6, 2, 1, 1'b0);

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 1) == 1)
                v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
            else
                v = $urandom;
            model(v, mf, mop, mc, mr);
            for (int k = 0; k < 3; k++) ml[k] = mf ? (mr / lanes[k]) + 1 : 16 / lanes[k];
            encode($sformatf("rnd%0d v=%08h", n, v), v, mf, mop, mc, ml[0], ml[1], ml[2],
                   $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
